ppu_reg_snoop: RTL
==================

Name: ppu_reg_snoop

Overview:
- Upstream stage of the video output path: passively snoops SNES B-bus writes and keeps shadow copies of the PPU registers the RGB scaler/OSD stage needs (brightness, force blank, BG mode, mode-7 screen-over, SETINI flags).
- Also measures frame timing from VBLANK/HBLANK: lines per frame, PAL/NTSC detection, interlace field parity, and a frame-start strobe.
- Runs on the master clock (MCLK, about 21.477 MHz); all bus and blanking inputs are asynchronous to it.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for PAWR_n, VBLANK and HBLANK; ADDR/DATA are delayed by the same depth.
- PAL_LINE_THRESH, 287, a latched line count strictly greater than this value flags PAL.
- OVERSCAN_AT_VBLANK, 1, 1 = overscan/interlace shadow is applied at VBLANK rise; 0 = applied immediately.

Ports:
- CLK_i  in  1  master clock.
- RST_i  in  1  synchronous reset, active-high.
- PAWR_n_i  in  1  B-bus write strobe, active-low, asynchronous.
- PADDRESS_i  in  8  B-bus address, low byte of $21xx.
- DATA_i  in  8  data bus.
- VBLANK_i  in  1  PPU vertical blank, asynchronous.
- HBLANK_i  in  1  PPU horizontal blank, asynchronous.
- brightness_o  out  4  INIDISP[3:0].
- force_blank_o  out  1  INIDISP[7].
- bgmode_o  out  3  BGMODE[2:0].
- mode7_over_o  out  1  (bgmode==7) & M7SEL[7] & !M7SEL[6].
- overscan_o  out  1  SETINI[2].
- interlace_o  out  1  SETINI[0].
- pseudo_hires_o  out  1  SETINI[3].
- field_o  out  1  interlace field parity.
- pal_o  out  1  PAL timing detected.
- line_count_o  out  9  lines counted in the previous frame.
- frame_start_o  out  1  one-cycle pulse at VBLANK rise.
- wr_strobe_o  out  1  one-cycle pulse on every committed write, decoded or not.

Behaviour:
- Reset values: brightness 4'hF, all other flags 0, bgmode 0, line_count 0, pal 0, field 0, all pulses 0. Internal pending-SETINI register clears to 0.
- Synchronisation: PAWR_n, VBLANK and HBLANK each pass through a SYNC_STAGES flop chain. ADDR and DATA pass through an equal-length pipeline so they stay aligned with the strobe. The edge-detector "previous" flop for PAWR_n resets to 1, so reset cannot produce a false rising edge.
- Write capture: each cycle the synchronised PAWR_n is 0, the aligned ADDR/DATA are loaded into a hold register. On the synchronised PAWR_n rising edge (previous 0, current 1), the hold register is committed.
  - Commit latency: SYNC_STAGES+1 cycles after the raw rising edge.
  - Minimum PAWR_n low width is SYNC_STAGES cycles; shorter pulses may be dropped, and that is acceptable.
- Decode at commit:
  - $00 sets brightness and force_blank.
  - $05 sets bgmode.
  - $1A sets the screen-over bit (D7 & !D6).
  - $33 sets pending SETINI {pseudo_hires, overscan, interlace}.
  - Any other address: no register change, but wr_strobe still pulses.
- SETINI apply:
  - OVERSCAN_AT_VBLANK=1: outputs load from pending at the VBLANK rise.
  - OVERSCAN_AT_VBLANK=0: outputs load at commit.
  - If a $33 commit and a VBLANK rise fall in the same cycle, the new data is applied (pending bypass).
- Line counter (9 bit):
  - Increments on each synchronised HBLANK rise while VBLANK is low; saturates at 511.
  - On a synchronised VBLANK rise: line_count_o <= counter; pal_o <= (counter > PAL_LINE_THRESH); counter clears; frame_start_o pulses.
  - field_o toggles at VBLANK rise if interlace_o (post-update value) is 1, else it is forced to 0.
  - If an HBLANK rise and a VBLANK rise occur in the same cycle, the HBLANK is not counted.
- Missing VBLANK: the counter holds at 511; pal_o and line_count_o keep their last values until the next VBLANK.
- Reset mid-write: the hold register and edge detector are cleared; the in-flight write is discarded.

Decomposition:
- Package snes_ppu_regs_pkg:
  - address constants ADDR_INIDISP=8'h00, ADDR_BGMODE=8'h05, ADDR_M7SEL=8'h1A, ADDR_SETINI=8'h33;
  - reset-value constants;
  - PAL/NTSC line-count localparams (NTSC 262, PAL 312).
- Sub-module sync_edge_det: N-stage synchroniser plus registered rise/fall pulses, instantiated three times (PAWR_n, VBLANK, HBLANK).

Test Plan:
- Reset, no bus activity -> brightness_o=4'hF, force_blank_o=0, bgmode_o=0, pal_o=0, wr_strobe_o never pulses.
- Write $00=8'h87 (PAWR_n low 6 cycles) -> brightness_o=7 and force_blank_o=1 exactly SYNC_STAGES+1 cycles after PAWR_n rises; wr_strobe_o pulses once.
- Write $05=8'h07, then $1A=8'h80 -> mode7_over_o=1. Then write $1A=8'hC0 -> mode7_over_o=0. A write to $21 changes nothing but does pulse wr_strobe_o.
- Write $33=8'h05 mid-frame with OVERSCAN_AT_VBLANK=1 -> overscan_o/interlace_o stay 0 until the next VBLANK rise, then both become 1. field_o toggles 0->1->0 over the next two VBLANK rises.
- 262 HBLANK pulses per frame -> line_count_o=262, pal_o=0. Then 312 per frame -> line_count_o=312, pal_o=1. 600 pulses -> line_count_o=511.
- Assert RST_i while PAWR_n is low during a $00=8'h03 write -> after reset, brightness_o=4'hF and no commit or wr_strobe_o pulse occurs when PAWR_n later rises.

Source files
------------

// File: rtl/snes_ppu_regs_pkg.sv
// Shared constants and types for the SNES PPU register snooper:
// B-bus register addresses, reset values and frame-timing reference counts.
package snes_ppu_regs_pkg;

    localparam logic [7:0] ADDR_INIDISP = 8'h00;
    localparam logic [7:0] ADDR_BGMODE  = 8'h05;
    localparam logic [7:0] ADDR_M7SEL   = 8'h1A;
    localparam logic [7:0] ADDR_SETINI  = 8'h33;

    localparam logic [3:0] RST_BRIGHTNESS = 4'hF;
    localparam logic [2:0] RST_BGMODE     = 3'd0;
    localparam logic [8:0] RST_LINE_COUNT = 9'd0;

    localparam int unsigned NTSC_LINES = 262;
    localparam int unsigned PAL_LINES  = 312;

    localparam logic [8:0] LINE_COUNT_MAX = 9'd511;

    typedef enum logic [2:0] {
        REG_INIDISP,
        REG_BGMODE,
        REG_M7SEL,
        REG_SETINI,
        REG_OTHER
    } ppu_reg_e;

    typedef struct packed {
        logic pseudo_hires;
        logic overscan;
        logic interlace;
    } setini_t;

    localparam setini_t RST_SETINI = '{pseudo_hires: 1'b0, overscan: 1'b0, interlace: 1'b0};

    function automatic ppu_reg_e decode_addr(input logic [7:0] addr);
        ppu_reg_e r;
        case (addr)
            ADDR_INIDISP: r = REG_INIDISP;
            ADDR_BGMODE:  r = REG_BGMODE;
            ADDR_M7SEL:   r = REG_M7SEL;
            ADDR_SETINI:  r = REG_SETINI;
            default:      r = REG_OTHER;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchroniser with registered rise/fall pulses aligned to the
// first cycle the synchronised level shows the new value.
module sync_edge_det #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [N:1] pipe_q;
    logic [N:1] vld_q;
    logic [N:0] pipe_w;
    logic [N:0] vld_w;
    logic       rise_q;
    logic       fall_q;

    assign pipe_w = {pipe_q, async_i};
    assign vld_w  = {vld_q, 1'b1};

    // vld_q marks stages holding real samples, so the reset fill value can
    // never be mistaken for an edge against the first real sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= {N{RST_VAL}};
            vld_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            pipe_q <= pipe_w[N-1:0];
            vld_q  <= vld_w[N-1:0];
            rise_q <= vld_q[N] &  pipe_w[N-1] & ~pipe_w[N];
            fall_q <= vld_q[N] & ~pipe_w[N-1] &  pipe_w[N];
        end
    end

    assign sync_o = pipe_q[N];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ppu_reg_snoop.sv
// Passive B-bus snooper keeping shadow PPU registers for the scaler/OSD
// stage, plus frame timing (line count, PAL detect, field, frame start).
module ppu_reg_snoop
    import snes_ppu_regs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned PAL_LINE_THRESH    = 287,
    parameter bit          OVERSCAN_AT_VBLANK = 1'b1
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       PAWR_n_i,
    input  logic [7:0] PADDRESS_i,
    input  logic [7:0] DATA_i,
    input  logic       VBLANK_i,
    input  logic       HBLANK_i,
    output logic [3:0] brightness_o,
    output logic       force_blank_o,
    output logic [2:0] bgmode_o,
    output logic       mode7_over_o,
    output logic       overscan_o,
    output logic       interlace_o,
    output logic       pseudo_hires_o,
    output logic       field_o,
    output logic       pal_o,
    output logic [8:0] line_count_o,
    output logic       frame_start_o,
    output logic       wr_strobe_o
);

    localparam logic [8:0] PAL_THRESH = 9'(PAL_LINE_THRESH);

    logic pawr_sync, pawr_rise, pawr_fall;
    logic vb_sync, vb_rise, vb_fall;
    logic hb_sync, hb_rise, hb_fall;
    logic unused_ok;

    sync_edge_det #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_pawr_sync (
        .clk_i(CLK_i), .rst_i(RST_i), .async_i(PAWR_n_i),
        .sync_o(pawr_sync), .rise_o(pawr_rise), .fall_o(pawr_fall)
    );

    sync_edge_det #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_vblank_sync (
        .clk_i(CLK_i), .rst_i(RST_i), .async_i(VBLANK_i),
        .sync_o(vb_sync), .rise_o(vb_rise), .fall_o(vb_fall)
    );

    sync_edge_det #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_hblank_sync (
        .clk_i(CLK_i), .rst_i(RST_i), .async_i(HBLANK_i),
        .sync_o(hb_sync), .rise_o(hb_rise), .fall_o(hb_fall)
    );

    assign unused_ok = &{1'b0, vb_fall, hb_sync, hb_fall};

    logic [SYNC_STAGES-1:0][15:0] bus_pipe_q;
    logic [15:0] bus_aligned;

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            bus_pipe_q <= '0;
        end else begin
            bus_pipe_q[0] <= {PADDRESS_i, DATA_i};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                bus_pipe_q[i] <= bus_pipe_q[i-1];
            end
        end
    end

    assign bus_aligned = bus_pipe_q[SYNC_STAGES-1];

    logic [15:0] hold_q, hold_d;
    logic        armed_q, armed_d;
    logic [3:0]  bright_q, bright_d;
    logic        fb_q, fb_d;
    logic [2:0]  bgmode_q, bgmode_d;
    logic        m7_over_q, m7_over_d;
    setini_t     pend_q, pend_d;
    setini_t     setini_q, setini_d;
    logic        field_q, field_d;
    logic        pal_q, pal_d;
    logic [8:0]  line_count_q, line_count_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        frame_start_q, frame_start_d;
    logic        wr_strobe_q, wr_strobe_d;

    logic        commit;
    logic [7:0]  wdata;
    setini_t     setini_new;

    always_comb begin
        hold_d        = hold_q;
        armed_d       = armed_q;
        bright_d      = bright_q;
        fb_d          = fb_q;
        bgmode_d      = bgmode_q;
        m7_over_d     = m7_over_q;
        pend_d        = pend_q;
        setini_d      = setini_q;
        field_d       = field_q;
        pal_d         = pal_q;
        line_count_d  = line_count_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;
        wr_strobe_d   = 1'b0;

        wdata      = hold_q[7:0];
        setini_new = '{pseudo_hires: wdata[3], overscan: wdata[2], interlace: wdata[0]};

        // A commit needs a falling edge seen since reset, so a write that was
        // already in flight when reset hit is discarded on its rising edge.
        commit = pawr_rise & armed_q;

        if (!pawr_sync) begin
            hold_d = bus_aligned;
        end
        if (pawr_fall) begin
            armed_d = 1'b1;
        end

        if (commit) begin
            armed_d     = 1'b0;
            wr_strobe_d = 1'b1;
            case (decode_addr(hold_q[15:8]))
                REG_INIDISP: begin
                    bright_d = wdata[3:0];
                    fb_d     = wdata[7];
                end
                REG_BGMODE: bgmode_d  = wdata[2:0];
                REG_M7SEL:  m7_over_d = wdata[7] & ~wdata[6];
                REG_SETINI: begin
                    pend_d = setini_new;
                    if (!OVERSCAN_AT_VBLANK) begin
                        setini_d = setini_new;
                    end
                end
                default: ;
            endcase
        end

        if (vb_rise) begin
            // pend_d already carries a same-cycle $33 commit (pending bypass)
            if (OVERSCAN_AT_VBLANK) begin
                setini_d = pend_d;
            end
            field_d       = setini_d.interlace ? ~field_q : 1'b0;
            line_count_d  = cnt_q;
            pal_d         = (cnt_q > PAL_THRESH);
            cnt_d         = '0;
            frame_start_d = 1'b1;
        end else if (hb_rise && !vb_sync && (cnt_q != LINE_COUNT_MAX)) begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            hold_q        <= '0;
            armed_q       <= 1'b0;
            bright_q      <= RST_BRIGHTNESS;
            fb_q          <= 1'b0;
            bgmode_q      <= RST_BGMODE;
            m7_over_q     <= 1'b0;
            pend_q        <= RST_SETINI;
            setini_q      <= RST_SETINI;
            field_q       <= 1'b0;
            pal_q         <= 1'b0;
            line_count_q  <= RST_LINE_COUNT;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            wr_strobe_q   <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            armed_q       <= armed_d;
            bright_q      <= bright_d;
            fb_q          <= fb_d;
            bgmode_q      <= bgmode_d;
            m7_over_q     <= m7_over_d;
            pend_q        <= pend_d;
            setini_q      <= setini_d;
            field_q       <= field_d;
            pal_q         <= pal_d;
            line_count_q  <= line_count_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            wr_strobe_q   <= wr_strobe_d;
        end
    end

    assign brightness_o   = bright_q;
    assign force_blank_o  = fb_q;
    assign bgmode_o       = bgmode_q;
    assign mode7_over_o   = (bgmode_q == 3'd7) & m7_over_q;
    assign overscan_o     = setini_q.overscan;
    assign interlace_o    = setini_q.interlace;
    assign pseudo_hires_o = setini_q.pseudo_hires;
    assign field_o        = field_q;
    assign pal_o          = pal_q;
    assign line_count_o   = line_count_q;
    assign frame_start_o  = frame_start_q;
    assign wr_strobe_o    = wr_strobe_q;

endmodule
